// File: rtl/frogger_pkg.sv
// Shared frogger types: the game state and sound enums used by game_ctrl,
// ui_gen and the sound player, plus the level and timer widths.
package frogger_pkg;

  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [1:0] {
    MENU    = 2'd0,
    PLAYING = 2'd1,
    DEAD    = 2'd2,
    WIN     = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    UI_PRESS    = 2'd0,
    NEXTLEVEL   = 2'd1,
    CRASH       = 2'd2,
    CELEBRATION = 2'd3
  } sound_t;

endpackage

// File: rtl/game_ctrl_frame_countdown.sv
// frame_countdown: loadable frame counter for the DEAD/WIN screen hold.
// It decrements on each frame tick while non-zero. expire_o is combinational
// and fires in the cycle of the tick that takes the count from 1 to 0, so the
// owning FSM can leave its hold state on the very next clock edge.
module frame_countdown
  import frogger_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] value_i,
  input  logic               tick_i,
  output logic               expire_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  // Next count: a load takes priority over a tick; the count stops at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expire_o = tick_i && !load_i && (count_q == TIMER_W'(1));

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: frogger game-flow sequencer. It owns the MENU/PLAYING/DEAD/WIN
// state, the level and lives registers and the sound request register. It
// turns frog events into state changes, frog respawn pulses and sound
// requests. All outputs are registered.
// Optional feature macro: GAME_CTRL_LIVES_EN (multiple lives per game).
module game_ctrl
  import frogger_pkg::*;
#(
  parameter logic [3:0] MAX_LEVEL   = 4'd9,
  parameter logic [7:0] DEAD_FRAMES = 8'd120,
  parameter logic [7:0] WIN_FRAMES  = 8'd240,
  parameter logic [1:0] NUM_LIVES   = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_any_tick,
  input  logic       collision,
  input  logic       goal_reached,
  input  logic       sound_ack,
  output logic [1:0] state,
  output logic [3:0] level,
  output logic [1:0] lives,
  output logic       frog_reset,
  output logic       sound_req,
  output logic [1:0] sound_id
);

  game_state_t        state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               frog_reset_q, frog_reset_d;
  logic               sound_req_q, sound_req_d;
  sound_t             sound_id_q, sound_id_d;

  logic               snd_evt;
  sound_t             snd_new;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_expire;

`ifdef GAME_CTRL_LIVES_EN
  logic [1:0]         lives_q, lives_d;
`endif

  frame_countdown u_hold (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .tick_i   (frame_tick),
    .expire_o (tmr_expire)
  );

  // Next-state, level/lives updates and sound event selection.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    frog_reset_d = 1'b0;
    snd_evt      = 1'b0;
    snd_new      = sound_id_q;
    tmr_load     = 1'b0;
    tmr_value    = '0;
`ifdef GAME_CTRL_LIVES_EN
    lives_d      = lives_q;
`endif
    case (state_q)
      MENU: begin
        if (btn_any_tick) begin
          state_d      = PLAYING;
          level_d      = LEVEL_W'(1);
          frog_reset_d = 1'b1;
          snd_evt      = 1'b1;
          snd_new      = UI_PRESS;
`ifdef GAME_CTRL_LIVES_EN
          lives_d      = NUM_LIVES;
`endif
        end
      end
      PLAYING: begin
        if (collision) begin
          snd_evt = 1'b1;
          snd_new = CRASH;
`ifdef GAME_CTRL_LIVES_EN
          if (lives_q > 2'd1) begin
            lives_d      = lives_q - 2'd1;
            frog_reset_d = 1'b1;
          end else begin
            lives_d   = '0;
            state_d   = DEAD;
            tmr_load  = 1'b1;
            tmr_value = DEAD_FRAMES;
          end
`else
          state_d   = DEAD;
          tmr_load  = 1'b1;
          tmr_value = DEAD_FRAMES;
`endif
        end else if (goal_reached) begin
          snd_evt = 1'b1;
          if (level_q < MAX_LEVEL) begin
            level_d      = level_q + 1'b1;
            frog_reset_d = 1'b1;
            snd_new      = NEXTLEVEL;
          end else begin
            state_d   = WIN;
            snd_new   = CELEBRATION;
            tmr_load  = 1'b1;
            tmr_value = WIN_FRAMES;
          end
        end
      end
      DEAD, WIN: begin
        if (tmr_expire) state_d = MENU;
      end
      default: state_d = MENU;
    endcase

    // Latest event wins; an event in the same cycle as an ack keeps the request up.
    if (snd_evt)        sound_req_d = 1'b1;
    else if (sound_ack) sound_req_d = 1'b0;
    else                sound_req_d = sound_req_q;
    sound_id_d = snd_evt ? snd_new : sound_id_q;
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MENU;
      level_q      <= LEVEL_W'(1);
      frog_reset_q <= 1'b0;
      sound_req_q  <= 1'b0;
      sound_id_q   <= UI_PRESS;
`ifdef GAME_CTRL_LIVES_EN
      lives_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      frog_reset_q <= frog_reset_d;
      sound_req_q  <= sound_req_d;
      sound_id_q   <= sound_id_d;
`ifdef GAME_CTRL_LIVES_EN
      lives_q      <= lives_d;
`endif
    end
  end

  assign state      = state_q;
  assign level      = level_q;
  assign frog_reset = frog_reset_q;
  assign sound_req  = sound_req_q;
  assign sound_id   = sound_id_q;
`ifdef GAME_CTRL_LIVES_EN
  assign lives      = lives_q;
`else
  // Always zero; the AND keeps NUM_LIVES referenced when lives are compiled out.
  assign lives      = NUM_LIVES & 2'b00;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl with default parameters.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_game_ctrl;
  import frogger_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_any_tick = 1'b0;
  logic       collision = 1'b0;
  logic       goal_reached = 1'b0;
  logic       sound_ack = 1'b0;
  logic [1:0] state;
  logic [3:0] level;
  logic [1:0] lives;
  logic       frog_reset;
  logic       sound_req;
  logic [1:0] sound_id;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  game_ctrl #(
    .MAX_LEVEL   (4'd9),
    .DEAD_FRAMES (8'd120),
    .WIN_FRAMES  (8'd240),
    .NUM_LIVES   (2'd3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .btn_any_tick (btn_any_tick),
    .collision    (collision),
    .goal_reached (goal_reached),
    .sound_ack    (sound_ack),
    .state        (state),
    .level        (level),
    .lives        (lives),
    .frog_reset   (frog_reset),
    .sound_req    (sound_req),
    .sound_id     (sound_id)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic frames(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
    end
  endtask

  task automatic goal();
    goal_reached = 1'b1; cyc(); goal_reached = 1'b0; cyc();
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    chk("rst_state", 8'(state), 8'(MENU));
    chk("rst_level", 8'(level), 8'd1);
    chk("rst_lives", 8'(lives), 8'd0);
    chk("rst_frog_reset", 8'(frog_reset), 8'd0);
    chk("rst_sound_req", 8'(sound_req), 8'd0);
    chk("rst_sound_id", 8'(sound_id), 8'(UI_PRESS));
    rst = 1'b0;
    cyc();

    // Game start from MENU
    btn_any_tick = 1'b1; cyc(); btn_any_tick = 1'b0;
    chk("start_state", 8'(state), 8'(PLAYING));
    chk("start_level", 8'(level), 8'd1);
    chk("start_frog_reset", 8'(frog_reset), 8'd1);
    chk("start_sound_req", 8'(sound_req), 8'd1);
    chk("start_sound_id", 8'(sound_id), 8'(UI_PRESS));
`ifdef GAME_CTRL_LIVES_EN
    chk("start_lives", 8'(lives), 8'd3);
`endif
    cyc();
    chk("start_frog_reset_1cyc", 8'(frog_reset), 8'd0);
    chk("start_req_held", 8'(sound_req), 8'd1);
    sound_ack = 1'b1; cyc(); sound_ack = 1'b0;
    chk("ack_clears_req", 8'(sound_req), 8'd0);

    // Level progression to MAX_LEVEL, then WIN
    goal_reached = 1'b1; cyc(); goal_reached = 1'b0;
    chk("goal1_level", 8'(level), 8'd2);
    chk("goal1_frog_reset", 8'(frog_reset), 8'd1);
    chk("goal1_sound_id", 8'(sound_id), 8'(NEXTLEVEL));
    cyc();
    for (int unsigned i = 0; i < 7; i++) goal();
    chk("goal8_level", 8'(level), 8'd9);
    chk("goal8_state", 8'(state), 8'(PLAYING));
    btn_any_tick = 1'b1; cyc(); btn_any_tick = 1'b0;
    chk("btn_in_play_state", 8'(state), 8'(PLAYING));
    chk("btn_in_play_frog_reset", 8'(frog_reset), 8'd0);
    goal_reached = 1'b1; cyc(); goal_reached = 1'b0;
    chk("win_state", 8'(state), 8'(WIN));
    chk("win_sound_id", 8'(sound_id), 8'(CELEBRATION));
    chk("win_sound_req", 8'(sound_req), 8'd1);
    chk("win_level", 8'(level), 8'd9);
    chk("win_frog_reset", 8'(frog_reset), 8'd0);
    cyc();
    collision = 1'b1; cyc(); collision = 1'b0;
    chk("win_ignores_collision", 8'(state), 8'(WIN));
    frames(239);
    chk("win_held_239", 8'(state), 8'(WIN));
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    chk("win_to_menu", 8'(state), 8'(MENU));
    chk("win_level_held", 8'(level), 8'd9);

    // Reset in the middle of a game at level 5 with a sound pending
    btn_any_tick = 1'b1; cyc(); btn_any_tick = 1'b0;
    chk("restart_level", 8'(level), 8'd1);
    cyc();
    for (int unsigned i = 0; i < 4; i++) goal();
    chk("pre_rst_level", 8'(level), 8'd5);
    chk("pre_rst_req", 8'(sound_req), 8'd1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_state", 8'(state), 8'(MENU));
    chk("mid_rst_level", 8'(level), 8'd1);
    chk("mid_rst_req", 8'(sound_req), 8'd0);
    cyc();

    // Simultaneous collision and goal at level 3
    btn_any_tick = 1'b1; cyc(); btn_any_tick = 1'b0;
    sound_ack = 1'b1; cyc(); sound_ack = 1'b0;
    goal(); goal();
    chk("lvl3_level", 8'(level), 8'd3);
`ifdef GAME_CTRL_LIVES_EN
    collision = 1'b1; cyc(); collision = 1'b0;
    chk("life1_state", 8'(state), 8'(PLAYING));
    chk("life1_lives", 8'(lives), 8'd2);
    chk("life1_frog_reset", 8'(frog_reset), 8'd1);
    cyc();
    collision = 1'b1; cyc(); collision = 1'b0;
    chk("life2_state", 8'(state), 8'(PLAYING));
    chk("life2_lives", 8'(lives), 8'd1);
    chk("life2_frog_reset", 8'(frog_reset), 8'd1);
    cyc();
`endif
    collision = 1'b1; goal_reached = 1'b1; cyc();
    collision = 1'b0; goal_reached = 1'b0;
    chk("both_state", 8'(state), 8'(DEAD));
    chk("both_sound_id", 8'(sound_id), 8'(CRASH));
    chk("both_level", 8'(level), 8'd3);
    chk("both_lives", 8'(lives), 8'd0);
    chk("both_frog_reset", 8'(frog_reset), 8'd0);
    frames(119);
    chk("dead_held_119", 8'(state), 8'(DEAD));
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    chk("dead_to_menu", 8'(state), 8'(MENU));
    chk("dead_level_held", 8'(level), 8'd3);

    // Sound handshake: overwrite while pending, ack coinciding with an event
    btn_any_tick = 1'b1; cyc(); btn_any_tick = 1'b0;
    cyc();
    goal_reached = 1'b1; sound_ack = 1'b1; cyc();
    goal_reached = 1'b0; sound_ack = 1'b0;
    chk("ack_with_event_req", 8'(sound_req), 8'd1);
    chk("ack_with_event_id", 8'(sound_id), 8'(NEXTLEVEL));
    cyc();
    collision = 1'b1; cyc(); collision = 1'b0;
    chk("overwrite_req", 8'(sound_req), 8'd1);
    chk("overwrite_id", 8'(sound_id), 8'(CRASH));
`ifdef GAME_CTRL_LIVES_EN
    chk("overwrite_lives", 8'(lives), 8'd2);
`else
    chk("overwrite_state", 8'(state), 8'(DEAD));
`endif
    sound_ack = 1'b1; cyc(); sound_ack = 1'b0;
    chk("final_ack_req", 8'(sound_req), 8'd0);
    sound_ack = 1'b1; cyc(); sound_ack = 1'b0;
    chk("idle_ack_req", 8'(sound_req), 8'd0);
    chk("idle_ack_id", 8'(sound_id), 8'(CRASH));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
